// File: rtl/regfile_pkg.sv
// Shared constants and types for the rv32i register file slice.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_NUM_RD = 2;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_onehot_wr_decoder.sv
// Enable-gated N-to-2^N one-hot decoder.
module onehot_decoder #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]      a_i,
  input  logic              en_i,
  output logic [2**N-1:0]   out_o
);

  localparam int unsigned OUT_W = 2**N;

  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign out_o[i] = en_i & (a_i == N'(i));
  end

endmodule

// File: rtl/regfile_onehot_wr.sv
// Parametrised multi-read-port register file with one-hot write decode,
// optional hardwired-zero register 0 and optional write-to-read bypass.
module regfile_onehot_wr
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_RD   = RF_NUM_RD,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [2**ADDR_W-1:0]     wr_onehot_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  dec_onehot;
  logic [DATA_W-1:0] mem [DEPTH];

  onehot_decoder #(
    .N (ADDR_W)
  ) u_wr_dec (
    .a_i   (wr_addr_i),
    .en_i  (wr_en_i),
    .out_o (dec_onehot)
  );

  // Register 0 never gets a write strobe when it is hardwired to zero.
  always_comb begin
    wr_onehot_o = dec_onehot;
    if (ZERO_REG != 0) begin
      wr_onehot_o[0] = 1'b0;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] row_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          row_q <= '0;
        end else if (wr_onehot_o[i]) begin
          row_q <= wr_data_i;
        end
      end

      assign mem[i] = row_q;
    end
  end

  // Independent combinational read ports; zero-register masking wins over bypass.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem[addr];
      if (BYPASS != 0 && wr_en_i && addr == wr_addr_i) begin
        data = wr_data_i;
      end
      if (ZERO_REG != 0 && addr == '0) begin
        data = '0;
      end
    end

    assign rd_data_o[k*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed self-checking bench: default, bypass and small-corner configurations.
module tb_regfile_onehot_wr;

  logic        clk_i = 1'b0;
  logic        rst_ni;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic [31:0] onehot_a;
  logic [31:0] onehot_b;

  logic        c_wr_en;
  logic [2:0]  c_wr_addr;
  logic [7:0]  c_wr_data;
  logic [11:0] c_rd_addr;
  logic [31:0] c_rd_data;
  logic [7:0]  c_onehot;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  regfile_onehot_wr #(.ZERO_REG(1), .BYPASS(0)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .wr_onehot_o(onehot_a)
  );

  regfile_onehot_wr #(.ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .wr_onehot_o(onehot_b)
  );

  regfile_onehot_wr #(.ADDR_W(3), .DATA_W(8), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(c_wr_en), .wr_addr_i(c_wr_addr),
    .wr_data_i(c_wr_data), .rd_addr_i(c_rd_addr), .rd_data_o(c_rd_data),
    .wr_onehot_o(c_onehot)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int unsigned perm [32];
    int unsigned j;
    int unsigned tmp;
    logic [31:0] exp0;
    logic [31:0] exp1;

    rst_ni    = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = {5'd7, 5'd3};
    c_wr_en   = 1'b0;
    c_wr_addr = '0;
    c_wr_data = '0;
    c_rd_addr = '0;

    #2;
    chk("reset_rd_a", rd_data_a, 64'h0);
    chk("reset_onehot_a", onehot_a, 32'h0);
    chk("reset_rd_c", c_rd_data, 32'h0);
    #10;
    rst_ni = 1'b1;
    step();

    // Small corner configuration: r0 is ordinary, four ports.
    c_wr_en = 1'b1; c_wr_addr = 3'd0; c_wr_data = 8'hA5;
    #1;
    chk("c_onehot_r0", c_onehot, 8'h01);
    step();
    c_wr_addr = 3'd7; c_wr_data = 8'h5A;
    #1;
    chk("c_onehot_r7", c_onehot, 8'h80);
    step();
    c_wr_en = 1'b0;
    c_rd_addr = {3'd7, 3'd0, 3'd7, 3'd0};
    #1;
    chk("c_rd_mixed", c_rd_data, 32'h5AA55AA5);
    c_rd_addr = {3'd0, 3'd0, 3'd0, 3'd0};
    #1;
    chk("c_rd_all_r0", c_rd_data, 32'hA5A5A5A5);
    c_rd_addr = {3'd7, 3'd7, 3'd7, 3'd7};
    #1;
    chk("c_rd_all_r7", c_rd_data, 32'h5A5A5A5A);

    // Basic write to x7 on both 32-bit configurations.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr = {5'd7, 5'd7};
    #1;
    chk("wr_x7_onehot", onehot_a, 32'h00000080);
    chk("wr_x7_nobyp_old", rd_data_a, 64'h0);
    chk("wr_x7_byp", rd_data_b, {2{32'h12345678}});
    step();
    wr_en = 1'b0;
    #1;
    chk("rd_x7_a", rd_data_a, {2{32'h12345678}});
    chk("rd_x7_b", rd_data_b, {2{32'h12345678}});

    // x0 hardwire, including the same-cycle bypass case.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0_onehot_a", onehot_a, 32'h0);
    chk("x0_onehot_b", onehot_b, 32'h0);
    chk("x0_byp_b", rd_data_b, 64'h0);
    chk("x0_same_a", rd_data_a, 64'h0);
    step();
    wr_en = 1'b0;
    #1;
    chk("x0_after_a", rd_data_a, 64'h0);
    chk("x0_after_b", rd_data_b, 64'h0);

    // Bypass versus stored value on x3.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
    step();
    wr_data = 32'h22; rd_addr = {5'd7, 5'd3};
    #1;
    chk("byp0_x3", rd_data_a, {32'h12345678, 32'h11});
    chk("byp1_x3", rd_data_b, {32'h12345678, 32'h22});
    step();
    wr_en = 1'b0;
    #1;
    chk("x3_next_a", rd_data_a, {32'h12345678, 32'h22});
    chk("x3_next_b", rd_data_b, {32'h12345678, 32'h22});

    // Mid-simulation reset after writing x5; reset overrides a concurrent write.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0; wr_addr = 5'd9; rd_addr = {5'd5, 5'd5};
    #1;
    chk("onehot_idle", onehot_a, 32'h0);
    chk("x5_before_rst", rd_data_a, {2{32'hDEADBEEF}});
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_a", rd_data_a, 64'h0);
    chk("rst_async_c", c_rd_data, 32'h0);
    rd_addr = {5'd7, 5'd3};
    #1;
    chk("rst_async_x7x3", rd_data_a, 64'h0);
    step();
    rd_addr = {5'd5, 5'd5};
    #1;
    chk("rst_blocks_write", rd_data_a, 64'h0);
    wr_en = 1'b0;
    #1;
    rst_ni = 1'b1;
    #1;
    chk("x5_after_rst", rd_data_a, 64'h0);
    wr_en = 1'b1; wr_data = 32'hCAFEF00D;
    step();
    wr_en = 1'b0;
    #1;
    chk("first_wr_after_rst", rd_data_a, {2{32'hCAFEF00D}});

    // Full sweep of x1..x31 with one-hot monitoring, then shuffled reads.
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
      #1;
      chk($sformatf("sweep_onehot_%0d", i), onehot_a, 32'h1 << i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) perm[i] = 32'(i);
    for (int i = 31; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - perm[i]), 5'(perm[i])};
      exp0 = 32'(perm[i]) * 32'h01010101;
      exp1 = 32'(31 - perm[i]) * 32'h01010101;
      #1;
      chk($sformatf("sweep_rd_a_%0d", perm[i]), rd_data_a, {exp1, exp0});
      chk($sformatf("sweep_rd_b_%0d", perm[i]), rd_data_b, {exp1, exp0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
